uart_transceiver: RTL and testbench
===================================

Name: uart_transceiver

Overview:
- Full-duplex 8N1 UART block with an independent transmitter path and receiver path, sharing one clock and reset.
- The TX path serialises a byte on a single-cycle trigger.
- The RX path deserialises the serial input and flags each valid byte with a one-cycle pulse.
- Used as the host serial link of the SDRAM controller design; the bench verifies it in loopback with tx wired to rx.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 1_562_500: serial bit rate in bit/s.
- BIT_CYCLES (localparam): CLK_FREQ/BAUD, integer division; 64 at defaults; must be >= 4.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- tx_trig  input  1  single-cycle start request for a transmit.
- tx_data  input  8  byte to transmit; sampled only in the cycle tx_trig is accepted.
- tx  output  1  serial output; idles high.
- tx_busy  output  1  high while a frame is being transmitted.
- rx  input  1  serial input, asynchronous to clk.
- rx_data  output  8  last correctly received byte.
- po_flag  output  1  one-cycle pulse: rx_data has just been updated.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset values: tx=1, tx_busy=0, rx_data=0x00, po_flag=0, frame_err=0, both FSMs in IDLE.
- Reset mid-frame aborts immediately; tx returns to 1 asynchronously.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts BIT_CYCLES clocks, so a frame is 10*BIT_CYCLES clocks.
- TX FSM states: IDLE, START, DATA, STOP.
- IDLE: if tx_trig=1 and tx_busy=0, latch tx_data into a shift register. On the next edge tx=0 and tx_busy=1.
- tx_trig while tx_busy=1 is ignored; the latched byte is unaffected.
- tx is a registered output, glitch-free.
- START: tx=0 for BIT_CYCLES clocks. DATA: bit i on tx for BIT_CYCLES clocks, i=0..7. STOP: tx=1 for BIT_CYCLES clocks.
- After STOP, tx_busy drops and the FSM returns to IDLE. tx_busy is high for exactly 10*BIT_CYCLES cycles.
- A trigger in the first cycle tx_busy=0 is accepted, giving back-to-back frames with no extra idle bit.
- RX input conditioning: two-flop synchroniser on rx, reset to 1, plus a third register for falling-edge detection.
- RX FSM states: IDLE, START, DATA, STOP.
- IDLE: a synchronised 1->0 transition enters START.
- START: wait BIT_CYCLES/2 cycles and sample at mid-bit. If the sample is 1, it is a glitch: return to IDLE with no outputs. If 0, enter DATA.
- DATA: sample every BIT_CYCLES cycles at bit centres. Shift bits in LSB first; 8 samples.
- STOP: sample at the stop-bit centre.
  - Sample = 1: rx_data <= shifted byte and po_flag=1 for exactly one cycle.
  - Sample = 0: frame_err=1 for one cycle; rx_data unchanged; no po_flag.
  - Either way, return to IDLE immediately at the mid-stop sample so the next start edge is caught.
- rx_data holds its value between frames.
- Loopback latency: po_flag rises about 9.5*BIT_CYCLES + 3 cycles after tx first goes low.
- TX and RX paths are fully independent; simultaneous activity is allowed.

Test Plan:
- Loopback, defaults, rstn released at 100 ns. Bytes 0x55, 0xA3, 0x00, 0xFF, each sent with a 1-cycle tx_trig and 800-cycle spacing -> four po_flag pulses, rx_data = 0x55, 0xA3, 0x00, 0xFF in order, frame_err never high.
- Single tx of 0xA3 -> tx low 64 cycles, then bits 1,1,0,0,0,1,0,1 at 64 cycles each, then high 64 cycles. tx_busy high exactly 640 cycles starting the cycle after the trigger.
- tx_trig with 0x12 pulsed again 100 cycles into a 0x5A frame -> only 0x5A is transmitted; the second trigger is ignored.
- rx glitch low for 10 cycles, then high -> no po_flag, no frame_err, FSM back in IDLE, and the next valid frame 0x3C is received correctly.
- rx frame 0x81 with stop bit forced to 0 -> frame_err pulses once, no po_flag, rx_data keeps its previous value.
- rstn asserted mid-TX frame -> tx=1 and tx_busy=0 immediately. After release, a new trigger for 0x77 is received intact in loopback.

Source files
------------

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent registered transmitter and mid-bit-sampling receiver.
// Both paths share one clock and an asynchronous active-low reset.
module uart_transceiver #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 1_562_500
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_trig,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       po_flag,
  output logic       frame_err
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int HALF_BIT   = BIT_CYCLES / 2;
  localparam int CW         = $clog2(BIT_CYCLES);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // ---------------------------------------------------------------- TX path
  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_shreg, tx_shreg_n;
  logic          tx_r, tx_n;
  logic          busy_r, busy_n;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shreg <= tx_shreg_n;
      tx_r     <= tx_n;
      busy_r   <= busy_n;
    end
  end

  // tx and tx_busy are computed one cycle ahead so the pins come straight from flops.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shreg_n = tx_shreg;
    tx_n       = tx_r;
    busy_n     = busy_r;
    case (tx_state)
      TX_IDLE: begin
        if (tx_trig && !busy_r) begin
          tx_state_n = TX_START;
          tx_shreg_n = tx_data;
          tx_cnt_n   = '0;
          tx_n       = 1'b0;
          busy_n     = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_n       = tx_shreg[0];
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            tx_state_n = TX_STOP;
            tx_n       = 1'b1;
          end else begin
            tx_bit_n   = tx_bit + 1'b1;
            tx_shreg_n = {1'b0, tx_shreg[7:1]};
            tx_n       = tx_shreg[1];
          end
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_n = TX_IDLE;
          tx_cnt_n   = '0;
          busy_n     = 1'b0;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  assign tx      = tx_r;
  assign tx_busy = busy_r;

  // ---------------------------------------------------------------- RX path
  logic rx_s1, rx_s2, rx_s3;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  logic rx_fall;
  assign rx_fall = rx_s3 & ~rx_s2;

  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shreg, rx_shreg_n;
  logic [7:0]    rx_data_r, rx_data_n;
  logic          po_r, po_n;
  logic          ferr_r, ferr_n;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shreg  <= '0;
      rx_data_r <= '0;
      po_r      <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      rx_state  <= rx_state_n;
      rx_cnt    <= rx_cnt_n;
      rx_bit    <= rx_bit_n;
      rx_shreg  <= rx_shreg_n;
      rx_data_r <= rx_data_n;
      po_r      <= po_n;
      ferr_r    <= ferr_n;
    end
  end

  // The stop bit is judged at its centre and the FSM leaves immediately, so the
  // next start edge is never missed even with a slightly fast transmitter.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shreg_n = rx_shreg;
    rx_data_n  = rx_data_r;
    po_n       = 1'b0;
    ferr_n     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_n = RX_START;
          rx_cnt_n   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n = '0;
          if (rx_s2) begin
            rx_state_n = RX_IDLE;
          end else begin
            rx_state_n = RX_DATA;
            rx_bit_n   = '0;
          end
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shreg_n = {rx_s2, rx_shreg[7:1]};
          if (rx_bit == 3'd7) begin
            rx_state_n = RX_STOP;
          end else begin
            rx_bit_n = rx_bit + 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
          if (rx_s2) begin
            rx_data_n = rx_shreg;
            po_n      = 1'b1;
          end else begin
            ferr_n = 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  assign rx_data   = rx_data_r;
  assign po_flag   = po_r;
  assign frame_err = ferr_r;

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: loopback transfers, TX bit timing,
// ignored re-trigger, RX glitch rejection, framing error and mid-frame reset.
module tb_uart_transceiver;

  localparam int BC = 64;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tx_trig = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx;
  logic       tx_busy;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       po_flag;
  logic       frame_err;

  logic       loop_sel = 1'b1;
  logic       rx_drv = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  int po_cnt = 0;
  int ferr_cnt = 0;

  assign rx_line = loop_sel ? tx : rx_drv;

  uart_transceiver #(.CLK_FREQ(100_000_000), .BAUD(1_562_500)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .tx_trig   (tx_trig),
    .tx_data   (tx_data),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .rx        (rx_line),
    .rx_data   (rx_data),
    .po_flag   (po_flag),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (po_flag)   po_cnt   <= po_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Pulses tx_trig for one cycle; returns at the first negedge after the accepting edge.
  task automatic trigger(input logic [7:0] d);
    @(negedge clk);
    tx_trig = 1'b1;
    tx_data = d;
    @(negedge clk);
    tx_trig = 1'b0;
    tx_data = 8'hEE;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = fr[k];
      wait_cycles(BC);
    end
    rx_drv = 1'b1;
  endtask

  initial begin : stim
    logic [7:0]  bytes [4];
    logic [9:0]  fr;
    int          po0, fe0, busy_n;
    bytes[0] = 8'h55; bytes[1] = 8'hA3; bytes[2] = 8'h00; bytes[3] = 8'hFF;

    // Reset values
    #50;
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_po", po_flag, 0);
    check("rst_ferr", frame_err, 0);
    #50 rstn = 1'b1;
    wait_cycles(10);

    // Loopback of four bytes
    fe0 = ferr_cnt;
    for (int b = 0; b < 4; b++) begin
      po0 = po_cnt;
      trigger(bytes[b]);
      wait_cycles(799);
      check($sformatf("loop_po_%0d", b), po_cnt - po0, 1);
      check($sformatf("loop_data_%0d", b), rx_data, bytes[b]);
    end
    check("loop_ferr", ferr_cnt - fe0, 0);

    // TX bit timing for 0xA3 (i = cycles since the accepting edge, sampled mid-cycle)
    check("a3_idle_busy", tx_busy, 0);
    fr = {1'b1, 8'hA3, 1'b0};
    busy_n = 0;
    trigger(8'hA3);
    for (int i = 0; i < 700; i++) begin
      if (i > 0) @(negedge clk);
      if (tx_busy) busy_n++;
      if (i == 0) check("a3_busy_first", tx_busy, 1);
      if (i < 640 && (i % BC == 0 || i % BC == BC - 1))
        check($sformatf("a3_tx_c%0d", i), tx, fr[i / BC]);
      if (i == 640) begin
        check("a3_busy_end", tx_busy, 0);
        check("a3_tx_idle", tx, 1);
      end
    end
    check("a3_busy_len", busy_n, 640);
    check("a3_loop_data", rx_data, 8'hA3);

    // Re-trigger while busy is ignored
    wait_cycles(100);
    po0 = po_cnt;
    trigger(8'h5A);
    wait_cycles(99);
    tx_trig = 1'b1; tx_data = 8'h12;
    @(negedge clk);
    tx_trig = 1'b0;
    wait_cycles(700);
    check("retrig_po", po_cnt - po0, 1);
    check("retrig_data", rx_data, 8'h5A);
    wait_cycles(800);
    check("retrig_no_second", po_cnt - po0, 1);
    check("retrig_busy", tx_busy, 0);

    // RX glitch then valid frame
    loop_sel = 1'b0;
    rx_drv = 1'b1;
    wait_cycles(20);
    po0 = po_cnt; fe0 = ferr_cnt;
    rx_drv = 1'b0;
    wait_cycles(10);
    rx_drv = 1'b1;
    wait_cycles(200);
    check("glitch_po", po_cnt - po0, 0);
    check("glitch_ferr", ferr_cnt - fe0, 0);
    check("glitch_data", rx_data, 8'h5A);
    send_rx(8'h3C, 1'b1);
    wait_cycles(50);
    check("after_glitch_po", po_cnt - po0, 1);
    check("after_glitch_data", rx_data, 8'h3C);

    // Framing error
    po0 = po_cnt; fe0 = ferr_cnt;
    send_rx(8'h81, 1'b0);
    wait_cycles(50);
    check("ferr_cnt", ferr_cnt - fe0, 1);
    check("ferr_po", po_cnt - po0, 0);
    check("ferr_data_kept", rx_data, 8'h3C);

    // Reset in the middle of a TX frame
    loop_sel = 1'b1;
    wait_cycles(20);
    trigger(8'h55);
    wait_cycles(200);
    check("mid_busy_before", tx_busy, 1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", tx_busy, 0);
    wait_cycles(5);
    rstn = 1'b1;
    wait_cycles(5);
    po0 = po_cnt;
    trigger(8'h77);
    wait_cycles(799);
    check("post_rst_po", po_cnt - po0, 1);
    check("post_rst_data", rx_data, 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
